// File: rtl/led_pio_arbiter_if.sv
// Requester handshake and Avalon-MM PIO bus shared by led_pio_arbiter.
// master = arbiter side, slave = requesters plus the LED PIO slave port.
interface led_pio_arbiter_if #(
  parameter int NREQ  = 2,
  parameter int LED_W = 10
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*LED_W-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic [1:0]            avm_address;
  logic                  avm_chipselect;
  logic                  avm_write_n;
  logic [31:0]           avm_writedata;
  logic [31:0]           avm_readdata;

  modport master (
    input  req_valid, req_data, avm_readdata,
    output req_ready, avm_address, avm_chipselect, avm_write_n, avm_writedata
  );

  modport slave (
    output req_valid, req_data, avm_readdata,
    input  req_ready, avm_address, avm_chipselect, avm_write_n, avm_writedata
  );
endinterface

// File: rtl/led_pio_arbiter.sv
// Round-robin arbiter sharing the LED PIO register: accept, write, read back, report.
// Bus outputs and done come straight from flops; only req_ready is combinational.
module led_pio_arbiter #(
  parameter int NREQ  = 2,
  parameter int LED_W = 10,
  parameter int ID_W  = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  led_pio_arbiter_if.master pio,
  output logic              done,
  output logic [ID_W-1:0]   done_id,
  output logic              busy,
  input  logic              err_clear,
  output logic              err_sticky,
  output logic [7:0]        err_count,
  output logic [LED_W-1:0]  led_shadow
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR   = 2'd1,
    S_RD   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   last_q, last_d, id_q, id_d, done_id_q, done_id_d;
  logic [LED_W-1:0]  data_q, data_d, shadow_q, shadow_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              cs_q, cs_d, write_n_q, write_n_d, done_q, done_d;
  logic              busy_q, busy_d, sticky_q, sticky_d;
  logic [7:0]        err_count_q, err_count_d;
  logic              found_s, hit_s, mismatch_s;
  logic [ID_W-1:0]   cand_s, grant_id_s;
  logic [LED_W-1:0]  grant_data_s;
  logic [NREQ-1:0]   ready_s;
  logic              unused_rd_s;

  // Round-robin search starting just after the last requester served.
  always_comb begin
    found_s    = 1'b0;
    hit_s      = 1'b0;
    cand_s     = '0;
    grant_id_s = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand_s     = ID_W'((int'(last_q) + k) % NREQ);
      hit_s      = !found_s && (|(pio.req_valid & (NREQ'(1) << cand_s)));
      grant_id_s = hit_s ? cand_s : grant_id_s;
      found_s    = found_s | hit_s;
    end
  end

  // One-hot accept and data select for the winning requester.
  always_comb begin
    ready_s      = '0;
    grant_data_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      ready_s[i]   = (state_q == S_IDLE) && found_s && (grant_id_s == ID_W'(i));
      grant_data_s = (grant_id_s == ID_W'(i)) ? pio.req_data[i*LED_W +: LED_W] : grant_data_s;
    end
  end

  assign mismatch_s  = (state_q == S_RD) && (pio.avm_readdata[LED_W-1:0] != data_q);
  assign unused_rd_s = ^pio.avm_readdata;

  // Next-state, capture, readback verification and registered output decode.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    id_d     = id_q;
    data_d   = data_q;
    wdata_d  = wdata_q;
    shadow_d = shadow_q;
    case (state_q)
      S_IDLE: begin
        if (found_s) begin
          state_d = S_WR;
          last_d  = grant_id_s;
          id_d    = grant_id_s;
          data_d  = grant_data_s;
          wdata_d = 32'(grant_data_s);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WR: state_d = S_RD;
      S_RD: begin
        state_d  = S_DONE;
        shadow_d = mismatch_s ? shadow_q : data_q;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A clear in the same cycle as a mismatch wins.
    sticky_d    = err_clear ? 1'b0 : (sticky_q | mismatch_s);
    err_count_d = err_clear ? 8'd0 :
                  (mismatch_s && (err_count_q != 8'd255)) ? (err_count_q + 8'd1) : err_count_q;

    cs_d      = (state_d == S_WR) || (state_d == S_RD);
    write_n_d = (state_d != S_WR);
    done_d    = (state_d == S_DONE);
    done_id_d = done_d ? id_d : '0;
    busy_d    = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      last_q      <= ID_W'(NREQ - 1);
      id_q        <= '0;
      data_q      <= '0;
      wdata_q     <= 32'd0;
      shadow_q    <= '0;
      sticky_q    <= 1'b0;
      err_count_q <= 8'd0;
      cs_q        <= 1'b0;
      write_n_q   <= 1'b1;
      done_q      <= 1'b0;
      done_id_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      id_q        <= id_d;
      data_q      <= data_d;
      wdata_q     <= wdata_d;
      shadow_q    <= shadow_d;
      sticky_q    <= sticky_d;
      err_count_q <= err_count_d;
      cs_q        <= cs_d;
      write_n_q   <= write_n_d;
      done_q      <= done_d;
      done_id_q   <= done_id_d;
      busy_q      <= busy_d;
    end
  end

  assign pio.req_ready      = ready_s;
  assign pio.avm_address    = 2'b00;
  assign pio.avm_chipselect = cs_q;
  assign pio.avm_write_n    = write_n_q;
  assign pio.avm_writedata  = wdata_q;
  assign done               = done_q;
  assign done_id            = done_id_q;
  assign busy               = busy_q;
  assign err_sticky         = sticky_q;
  assign err_count          = err_count_q;
  assign led_shadow         = shadow_q;
endmodule

// File: tb/tb_led_pio_arbiter.sv
// Self-checking bench for led_pio_arbiter: directed scenarios plus a randomized run
// compared against a transaction-timeline reference model.
module tb_led_pio_arbiter;
  localparam int NREQ  = 2;
  localparam int LED_W = 10;
  localparam int ID_W  = 1;

  logic              clk = 1'b0;
  logic              reset_n = 1'b1;
  logic              err_clear = 1'b0;
  logic              force_rd0 = 1'b0;
  logic              done, busy, err_sticky;
  logic [ID_W-1:0]   done_id;
  logic [7:0]        err_count;
  logic [LED_W-1:0]  led_shadow;
  logic [LED_W-1:0]  slave_q = '0;

  int checks = 0;
  int errors = 0;

  int               m_last;
  logic [LED_W-1:0] m_shadow;
  int               m_cnt;
  logic             m_sticky;

  always #5 clk = ~clk;

  led_pio_arbiter_if #(.NREQ(NREQ), .LED_W(LED_W)) pio ();

  led_pio_arbiter #(.NREQ(NREQ), .LED_W(LED_W), .ID_W(ID_W)) dut (
    .clk(clk), .reset_n(reset_n), .pio(pio), .done(done), .done_id(done_id),
    .busy(busy), .err_clear(err_clear), .err_sticky(err_sticky),
    .err_count(err_count), .led_shadow(led_shadow)
  );

  // PIO slave model: one register at offset 0, readback optionally forced to zero.
  always @(posedge clk) begin
    if (pio.avm_chipselect && !pio.avm_write_n && pio.avm_address == 2'b00)
      slave_q <= pio.avm_writedata[LED_W-1:0];
  end
  assign pio.avm_readdata = force_rd0 ? 32'd0 : 32'(slave_q);

  // Round-robin rule: first valid requester after 'last', wrapping modulo NREQ.
  function automatic int pick(input logic [NREQ-1:0] v, input int last);
    for (int k = 1; k <= NREQ; k++)
      if (v[(last + k) % NREQ] == 1'b1) return (last + k) % NREQ;
    return -1;
  endfunction

  task automatic apply_reset();
    reset_n = 1'b0; pio.req_valid = '0; pio.req_data = '0; err_clear = 1'b0; force_rd0 = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    m_last = NREQ - 1; m_shadow = '0; m_cnt = 0; m_sticky = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    checks++; if (pio.req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b exp 00", pio.req_ready); end
    checks++; if (pio.avm_chipselect !== 1'b0 || pio.avm_write_n !== 1'b1) begin errors++; $display("FAIL reset_bus: got cs=%b wn=%b exp cs=0 wn=1", pio.avm_chipselect, pio.avm_write_n); end
    checks++; if (pio.avm_address !== 2'b00 || pio.avm_writedata !== 32'd0) begin errors++; $display("FAIL reset_addr_data: got %h/%h exp 0/0", pio.avm_address, pio.avm_writedata); end
    checks++; if (done !== 1'b0 || done_id !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_status: got done=%b id=%b busy=%b exp 0 0 0", done, done_id, busy); end
    checks++; if (err_sticky !== 1'b0 || err_count !== 8'd0 || led_shadow !== 10'd0) begin errors++; $display("FAIL reset_err: got %b %0d %h exp 0 0 0", err_sticky, err_count, led_shadow); end
  endtask

  task automatic test_single();
    @(negedge clk); pio.req_valid = 2'b01; pio.req_data = {10'h000, 10'h2A5}; #1;
    checks++; if (pio.req_ready !== 2'b01) begin errors++; $display("FAIL single_ready: got %b exp 01", pio.req_ready); end
    @(negedge clk); pio.req_valid = 2'b00; #1;
    checks++; if (pio.avm_chipselect !== 1'b1 || pio.avm_write_n !== 1'b0 || pio.avm_writedata !== 32'h000002A5) begin errors++; $display("FAIL single_write: got cs=%b wn=%b wd=%h exp 1 0 000002a5", pio.avm_chipselect, pio.avm_write_n, pio.avm_writedata); end
    checks++; if (busy !== 1'b1 || pio.req_ready !== 2'b00 || pio.avm_address !== 2'b00) begin errors++; $display("FAIL single_wr_misc: got busy=%b rdy=%b addr=%h exp 1 00 0", busy, pio.req_ready, pio.avm_address); end
    @(negedge clk); #1;
    checks++; if (pio.avm_chipselect !== 1'b1 || pio.avm_write_n !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL single_read: got cs=%b wn=%b done=%b exp 1 1 0", pio.avm_chipselect, pio.avm_write_n, done); end
    @(negedge clk); #1;
    checks++; if (done !== 1'b1 || done_id !== 1'b0 || pio.avm_chipselect !== 1'b0) begin errors++; $display("FAIL single_done: got done=%b id=%b cs=%b exp 1 0 0", done, done_id, pio.avm_chipselect); end
    checks++; if (led_shadow !== 10'h2A5 || err_count !== 8'd0) begin errors++; $display("FAIL single_shadow: got %h cnt=%0d exp 2a5 0", led_shadow, err_count); end
    @(negedge clk); #1;
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_idle: got done=%b busy=%b exp 0 0", done, busy); end
    m_last = 0; m_shadow = 10'h2A5;
  endtask

  task automatic test_contention();
    int g_id[$]; int g_cyc[$]; logic [31:0] wr[$];
    int exp_id[4]; logic [31:0] exp_wr[4];
    exp_id = '{0, 1, 0, 1}; exp_wr = '{32'h001, 32'h3FF, 32'h001, 32'h3FF};
    apply_reset();
    pio.req_data = {10'h3FF, 10'h001};
    for (int c = 0; c < 16; c++) begin
      @(negedge clk); pio.req_valid = (c <= 12) ? 2'b11 : 2'b00; #1;
      if ((pio.req_ready & pio.req_valid) != 2'b00) begin g_id.push_back(pio.req_ready[1] ? 1 : 0); g_cyc.push_back(c); end
      if (pio.avm_chipselect && !pio.avm_write_n) wr.push_back(pio.avm_writedata);
    end
    checks++; if (g_id.size() != 4 || wr.size() != 4) begin errors++; $display("FAIL cont_count: got grants=%0d writes=%0d exp 4 4", g_id.size(), wr.size()); end
    for (int i = 0; i < 4 && i < g_id.size() && i < wr.size(); i++) begin
      checks++; if (g_id[i] != exp_id[i] || g_cyc[i] != 4 * i) begin errors++; $display("FAIL cont_grant%0d: got id=%0d cyc=%0d exp id=%0d cyc=%0d", i, g_id[i], g_cyc[i], exp_id[i], 4 * i); end
      checks++; if (wr[i] !== exp_wr[i]) begin errors++; $display("FAIL cont_write%0d: got %h exp %h", i, wr[i], exp_wr[i]); end
    end
    m_last = 1; m_shadow = 10'h3FF;
  endtask

  task automatic test_mismatch();
    @(negedge clk); pio.req_valid = 2'b01; pio.req_data = {10'h000, 10'h155}; force_rd0 = 1'b1; #1;
    checks++; if (pio.req_ready !== 2'b01) begin errors++; $display("FAIL mism_ready: got %b exp 01", pio.req_ready); end
    repeat (2) begin @(negedge clk); pio.req_valid = 2'b00; end
    @(negedge clk); #1;
    checks++; if (done !== 1'b1 || done_id !== 1'b0) begin errors++; $display("FAIL mism_done: got done=%b id=%b exp 1 0", done, done_id); end
    checks++; if (err_sticky !== 1'b1 || err_count !== 8'd1) begin errors++; $display("FAIL mism_err: got sticky=%b cnt=%0d exp 1 1", err_sticky, err_count); end
    checks++; if (led_shadow !== m_shadow) begin errors++; $display("FAIL mism_shadow: got %h exp %h", led_shadow, m_shadow); end
    force_rd0 = 1'b0; m_last = 0; m_cnt = 1; m_sticky = 1'b1;
  endtask

  task automatic test_saturation();
    int ndone = 0; int exp_cnt;
    force_rd0 = 1'b1; pio.req_data = {10'h000, 10'h155};
    for (int c = 0; c < 260 * 4 + 40 && ndone < 260; c++) begin
      @(negedge clk); pio.req_valid = 2'b01; #1;
      if (done === 1'b1) begin
        ndone++;
        exp_cnt = (m_cnt + ndone > 255) ? 255 : m_cnt + ndone;
        checks++; if (err_count !== 8'(exp_cnt)) begin errors++; $display("FAIL sat_count%0d: got %0d exp %0d", ndone, err_count, exp_cnt); end
      end
    end
    @(negedge clk); pio.req_valid = 2'b00;
    checks++; if (ndone != 260) begin errors++; $display("FAIL sat_timeout: got %0d done pulses exp 260", ndone); end
    checks++; if (err_count !== 8'd255 || err_sticky !== 1'b1) begin errors++; $display("FAIL sat_hold: got cnt=%0d sticky=%b exp 255 1", err_count, err_sticky); end
    // err_clear lands on the RD cycle of another mismatching write
    repeat (2) @(negedge clk);
    pio.req_valid = 2'b01; #1;
    checks++; if (pio.req_ready !== 2'b01) begin errors++; $display("FAIL clr_ready: got %b exp 01", pio.req_ready); end
    @(negedge clk); pio.req_valid = 2'b00;
    @(negedge clk); err_clear = 1'b1; #1;
    checks++; if (err_count !== 8'd255 || pio.avm_write_n !== 1'b1 || pio.avm_chipselect !== 1'b1) begin errors++; $display("FAIL clr_pre: got cnt=%0d cs=%b wn=%b exp 255 1 1", err_count, pio.avm_chipselect, pio.avm_write_n); end
    @(negedge clk); err_clear = 1'b0; #1;
    checks++; if (err_count !== 8'd0 || err_sticky !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL clr_win: got cnt=%0d sticky=%b done=%b exp 0 0 1", err_count, err_sticky, done); end
    force_rd0 = 1'b0; m_cnt = 0; m_sticky = 1'b0; m_last = 0;
  endtask

  task automatic test_reset_wr();
    int nd = 0;
    @(negedge clk); pio.req_valid = 2'b10; pio.req_data = {10'h0AA, 10'h123}; #1;
    checks++; if (pio.req_ready !== 2'b10) begin errors++; $display("FAIL rwr_ready: got %b exp 10", pio.req_ready); end
    @(negedge clk); pio.req_valid = 2'b00; #1;
    checks++; if (pio.avm_chipselect !== 1'b1 || pio.avm_write_n !== 1'b0) begin errors++; $display("FAIL rwr_inwr: got cs=%b wn=%b exp 1 0", pio.avm_chipselect, pio.avm_write_n); end
    reset_n = 1'b0; #1;
    checks++; if (pio.avm_chipselect !== 1'b0 || pio.avm_write_n !== 1'b1 || busy !== 1'b0 || led_shadow !== 10'd0) begin errors++; $display("FAIL rwr_async: got cs=%b wn=%b busy=%b shadow=%h exp 1'b0 1 0 0", pio.avm_chipselect, pio.avm_write_n, busy, led_shadow); end
    @(negedge clk); reset_n = 1'b1;
    m_last = NREQ - 1; m_shadow = '0; m_cnt = 0; m_sticky = 1'b0;
    for (int c = 0; c < 6; c++) begin @(negedge clk); #1; if (done === 1'b1 || busy === 1'b1) nd++; end
    checks++; if (nd != 0) begin errors++; $display("FAIL rwr_nodone: got %0d active cycles exp 0", nd); end
    @(negedge clk); pio.req_valid = 2'b11; #1;
    checks++; if (pio.req_ready !== 2'b01) begin errors++; $display("FAIL rwr_prio: got %b exp 01", pio.req_ready); end
    @(negedge clk); pio.req_valid = 2'b00;
    @(negedge clk);
    @(negedge clk); #1;
    checks++; if (done !== 1'b1 || done_id !== 1'b0 || led_shadow !== 10'h123) begin errors++; $display("FAIL rwr_after: got done=%b id=%b shadow=%h exp 1 0 123", done, done_id, led_shadow); end
    m_last = 0; m_shadow = 10'h123;
  endtask

  task automatic test_withdrawn();
    int nd = 0; int r1 = 0; logic [ID_W-1:0] lid = '1;
    pio.req_data = {10'h2C3, 10'h0F0};
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      pio.req_valid = (c == 0) ? 2'b01 : (c == 2) ? 2'b10 : 2'b00; #1;
      if (pio.req_ready[1] === 1'b1) r1++;
      if (done === 1'b1) begin nd++; lid = done_id; end
    end
    checks++; if (r1 != 0) begin errors++; $display("FAIL wd_grant1: got %0d grants exp 0", r1); end
    checks++; if (nd != 1 || lid !== 1'b0) begin errors++; $display("FAIL wd_done: got %0d pulses id=%b exp 1 0", nd, lid); end
    checks++; if (led_shadow !== 10'h0F0) begin errors++; $display("FAIL wd_shadow: got %h exp 0f0", led_shadow); end
    m_last = 0; m_shadow = 10'h0F0;
  endtask

  task automatic test_random();
    int acc, acc_id, p; logic [LED_W-1:0] acc_data; logic acc_bad, mism;
    logic [NREQ-1:0] v, exp_ready; logic [LED_W-1:0] dv [NREQ];
    logic exp_cs, exp_wn, exp_done, exp_busy;
    apply_reset();
    acc = -10; acc_id = 0; acc_data = '0; acc_bad = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      v = NREQ'($urandom_range(0, 3));
      for (int i = 0; i < NREQ; i++) dv[i] = LED_W'($urandom_range(0, 1023));
      pio.req_valid = v; pio.req_data = {dv[1], dv[0]};
      err_clear = ($urandom_range(0, 15) == 0);
      force_rd0 = (c == acc + 2) && acc_bad;
      #1;
      p = (c >= acc + 4) ? pick(v, m_last) : -1;
      exp_ready = (p >= 0) ? NREQ'(1 << p) : '0;
      exp_cs = (c == acc + 1) || (c == acc + 2); exp_wn = (c != acc + 1);
      exp_done = (c == acc + 3); exp_busy = (c > acc) && (c <= acc + 3);
      checks++; if (pio.req_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready c%0d: got %b exp %b", c, pio.req_ready, exp_ready); end
      checks++; if (pio.avm_chipselect !== exp_cs || pio.avm_write_n !== exp_wn) begin errors++; $display("FAIL rnd_bus c%0d: got cs=%b wn=%b exp %b %b", c, pio.avm_chipselect, pio.avm_write_n, exp_cs, exp_wn); end
      checks++; if (done !== exp_done || busy !== exp_busy) begin errors++; $display("FAIL rnd_status c%0d: got done=%b busy=%b exp %b %b", c, done, busy, exp_done, exp_busy); end
      checks++; if (err_count !== 8'(m_cnt) || err_sticky !== m_sticky || led_shadow !== m_shadow) begin errors++; $display("FAIL rnd_err c%0d: got %0d %b %h exp %0d %b %h", c, err_count, err_sticky, led_shadow, m_cnt, m_sticky, m_shadow); end
      if (c == acc + 1) begin checks++; if (pio.avm_writedata !== 32'(acc_data)) begin errors++; $display("FAIL rnd_wdata c%0d: got %h exp %h", c, pio.avm_writedata, 32'(acc_data)); end end
      if (exp_done) begin checks++; if (done_id !== ID_W'(acc_id)) begin errors++; $display("FAIL rnd_id c%0d: got %0d exp %0d", c, done_id, acc_id); end end
      mism = 1'b0;
      if (c == acc + 2) begin mism = acc_bad && (acc_data != '0); if (!mism) m_shadow = acc_data; end
      if (err_clear) begin m_cnt = 0; m_sticky = 1'b0; end
      else if (mism) begin m_sticky = 1'b1; if (m_cnt < 255) m_cnt++; end
      if (p >= 0) begin acc = c; acc_id = p; acc_data = dv[p]; acc_bad = ($urandom_range(0, 3) == 0); m_last = p; end
    end
    pio.req_valid = '0; err_clear = 1'b0; force_rd0 = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_mismatch();
    test_saturation();
    test_reset_wr();
    test_withdrawn();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, exp completion before 500000");
    $fatal(1);
  end
endmodule

// File: doc/led_pio_arbiter.md
Name: led_pio_arbiter

Overview:
- Avalon-MM master that shares the 10-bit LED PIO output register between several on-chip requesters, e.g. the motor-status logic and the LCD/menu logic.
- Arbitrates round-robin and issues a single write to PIO offset 0, then reads the register back to confirm the write landed.
- Reports completion and verify errors to the requesters.
- Sits between the requester logic and the LED PIO slave port inside the Platform Designer system.

Parameters:
- NREQ, 2, number of requesters (2..8).
- LED_W, 10, LED data width (1..32).
- ID_W, 1, requester index width; must be at least ceil(log2(NREQ)) and at least 1.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  bit i: requester i has a value to write.
- req_data  in  NREQ*LED_W  requester i value in bits [i*LED_W +: LED_W].
- req_ready  out  NREQ  one-hot accept; a transfer happens when valid[i] and ready[i] are both high.
- avm_address  out  2  PIO register offset; always 0.
- avm_chipselect  out  1  PIO chip select.
- avm_write_n  out  1  PIO write strobe, active-low.
- avm_writedata  out  32  zero-extended LED value.
- avm_readdata  in  32  PIO readback; combinational from the slave.
- done  out  1  one-cycle completion pulse.
- done_id  out  ID_W  requester served; valid while done=1.
- busy  out  1  high when the FSM is not in IDLE.
- err_clear  in  1  synchronous clear of err_sticky and err_count.
- err_sticky  out  1  set on any readback mismatch.
- err_count  out  8  mismatch count, saturating at 255.
- led_shadow  out  LED_W  last value successfully verified.

Behaviour:
- Reset (asynchronous, active-low reset_n; clock clk):
  - State goes to IDLE.
  - req_ready=0, avm_chipselect=0, avm_write_n=1, avm_address=0, avm_writedata=0.
  - done=0, done_id=0, busy=0, err_sticky=0, err_count=0, led_shadow=0.
  - Round-robin pointer last=NREQ-1, so requester 0 has first priority.
- FSM states:
  - IDLE:
    - If any req_valid is high, pick the first set bit searching last+1, last+2, … modulo NREQ.
    - Assert req_ready for that bit combinationally in the same cycle.
    - On that edge: capture data and id, set last=id, go to WR.
    - If no req_valid is high, req_ready=0 and the FSM stays in IDLE.
  - WR, one cycle:
    - chipselect=1, write_n=0, address=0, writedata={zeros, captured data}.
    - Go to RD.
  - RD, one cycle:
    - chipselect=1, write_n=1, address=0.
    - Sample avm_readdata[LED_W-1:0] at the clock edge ending RD.
    - Match: led_shadow <= captured data.
    - Mismatch: err_sticky <= 1; err_count increments unless it is already 255.
    - In both cases go to DONE.
  - DONE, one cycle:
    - done=1, done_id=captured id.
    - Go to IDLE; no accept is made in the DONE cycle.
- Bus outputs and done are decoded from registered state only; they are glitch-free and carry no combinational path from req_valid.
- req_ready is the only combinational output and is high only in IDLE.
- Timing: accept at cycle T, write at T+1, read at T+2, done at T+3. The next accept is possible at T+4, so sustained throughput is 1 transfer per 4 cycles.
- busy=1 in WR, RD and DONE.
- Fairness: if all requesters are continuously valid, they are served in strict rotation.
- A requester may drop req_valid before it is accepted; no transfer occurs for it.
- req_data is sampled only in the accept cycle.
- err_clear:
  - Clears err_sticky and err_count.
  - If err_clear is high in the same cycle as a mismatch, the clear wins and both stay 0.
- Reset mid-operation:
  - Immediate return to IDLE with all outputs at reset values.
  - An interrupted transfer produces no done pulse.
  - led_shadow is set to 0.

Test Plan:
- Single write:
  - Stimulus: req_valid=01, req_data[0]=10'h2A5.
  - Response: ready[0] high at T; write of 32'h000002A5 at T+1; read at T+2; done=1 with done_id=0 at T+3; led_shadow=10'h2A5; err_count=0.
- Contention:
  - Stimulus: both valid continuously, data 10'h001 and 10'h3FF, starting from reset.
  - Response: grants in order 0,1,0,1; accepts at T, T+4, T+8; PIO writes alternate between the two values.
- Readback mismatch:
  - Stimulus: slave model forces readdata=0 during RD for a write of 10'h155.
  - Response: err_sticky=1 and err_count=1 after RD; led_shadow unchanged; done pulse still issued.
- Saturation and clear:
  - Stimulus: 260 mismatching writes.
  - Response: err_count holds at 255.
  - Stimulus: err_clear pulse coinciding with a mismatch.
  - Response: err_count=0 and err_sticky=0.
- Reset in WR:
  - Stimulus: assert reset_n=0 while in WR.
  - Response: chipselect drops to 0 immediately; no done pulse; after release, requester 0 has priority.
- Withdrawn request:
  - Stimulus: req_valid[1] pulses during requester 0's RD state only.
  - Response: no grant to requester 1; exactly one done pulse, with done_id=0.
